// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: FSM encoding and
// register-index constants used by the hazard comparator.
package core_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } state_e;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0 = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of the hazard controller's pipeline-facing signals. The master side
// is the pipeline (drives the ID/EX operand info, sees the stall controls);
// the slave side is the controller.
interface hazard_stall_ctrl_if
    import core_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic                 EX_MemRead_i;
    logic [REG_IDX_W-1:0] EX_rd_i;
    logic [REG_IDX_W-1:0] ID_rs1_i;
    logic [REG_IDX_W-1:0] ID_rs2_i;
    logic                 ID_uses_rs2_i;
    logic                 branch_taken_i;
    logic                 mem_stall_i;
    logic                 PCWrite_o;
    logic                 IFID_write_o;
    logic                 IFID_flush_o;
    logic                 bubble_sel_o;
    logic                 freeze_o;
    logic [CNT_W-1:0]     lu_cnt_o;
    logic [CNT_W-1:0]     miss_cyc_cnt_o;
    logic                 miss_timeout_o;

    modport master (
        output EX_MemRead_i, EX_rd_i, ID_rs1_i, ID_rs2_i, ID_uses_rs2_i,
               branch_taken_i, mem_stall_i,
        input  PCWrite_o, IFID_write_o, IFID_flush_o, bubble_sel_o, freeze_o,
               lu_cnt_o, miss_cyc_cnt_o, miss_timeout_o
    );

    modport slave (
        input  EX_MemRead_i, EX_rd_i, ID_rs1_i, ID_rs2_i, ID_uses_rs2_i,
               branch_taken_i, mem_stall_i,
        output PCWrite_o, IFID_write_o, IFID_flush_o, bubble_sel_o, freeze_o,
               lu_cnt_o, miss_cyc_cnt_o, miss_timeout_o
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear wins, otherwise step unless already at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use bubbles,
// data-cache miss freeze, ID-stage branch flush, perf counters and a
// miss-timeout watchdog.
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_stall_ctrl_if.slave bus
);
    localparam int              TMO_W   = $clog2(MISS_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MISS_TIMEOUT);

    state_e           state_q;
    state_e           state_d;
    logic             lu;
    logic             lu_bubble;
    logic             in_miss;
    logic             tmo_flag_q;
    logic             tmo_flag_d;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             bubble_sel;
    logic             freeze;

    // Load in EX whose destination feeds an ID source register (x0 never hazards)
    assign lu = bus.EX_MemRead_i && (bus.EX_rd_i != X0) &&
                ((bus.EX_rd_i == bus.ID_rs1_i) ||
                 (bus.ID_uses_rs2_i && (bus.EX_rd_i == bus.ID_rs2_i)));

    assign in_miss   = (state_q == ST_MISS);
    assign lu_bubble = !rst_i && !bus.mem_stall_i && lu;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus prioritised stall controls (cache stall > load-use > branch)
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        bubble_sel = 1'b0;
        freeze     = 1'b0;

        case (state_q)
            ST_RUN:  if (bus.mem_stall_i)  state_d = ST_MISS;
            ST_MISS: if (!bus.mem_stall_i) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (rst_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b1;
        end else if (bus.mem_stall_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            freeze     = 1'b1;
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b1;
        end else if (bus.branch_taken_i) begin
            ifid_flush = 1'b1;
        end
    end

    // Sticky watchdog flag: raised the edge after the run length hits the limit
    always_comb begin
        tmo_flag_d = tmo_flag_q;
        if (tmo_cnt == TMO_MAX) begin
            tmo_flag_d = 1'b1;
        end
    end

    // Watchdog flag register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_flag_q <= tmo_flag_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (lu_bubble),
        .cnt_o (lu_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (in_miss),
        .cnt_o (miss_cnt)
    );

    // Run-length of consecutive MISS cycles; held at the limit once reached
    sat_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (!in_miss),
        .en_i  (in_miss && (tmo_cnt != TMO_MAX)),
        .cnt_o (tmo_cnt)
    );

    assign bus.PCWrite_o      = pc_write;
    assign bus.IFID_write_o   = ifid_write;
    assign bus.IFID_flush_o   = ifid_flush;
    assign bus.bubble_sel_o   = bubble_sel;
    assign bus.freeze_o       = freeze;
    assign bus.lu_cnt_o       = lu_cnt;
    assign bus.miss_cyc_cnt_o = miss_cnt;
    assign bus.miss_timeout_o = tmo_flag_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic, every
// cycle compared against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
    localparam int CNT_W        = 4;
    localparam int MISS_TIMEOUT = 8;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(
        .CNT_W        (CNT_W),
        .MISS_TIMEOUT (MISS_TIMEOUT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    bit m_in_miss;
    int m_lu_cnt;
    int m_miss_cnt;
    int m_run_len;
    bit m_flag;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_lu();
        return bus.EX_MemRead_i && (bus.EX_rd_i != 0) &&
               ((bus.EX_rd_i == bus.ID_rs1_i) ||
                (bus.ID_uses_rs2_i && (bus.EX_rd_i == bus.ID_rs2_i)));
    endfunction

    task automatic check_all();
        bit e_pcw, e_ifw, e_fl, e_bub, e_frz;
        if (rst_i) begin
            {e_pcw, e_ifw, e_fl, e_bub, e_frz} = 5'b00010;
        end else if (bus.mem_stall_i) begin
            {e_pcw, e_ifw, e_fl, e_bub, e_frz} = 5'b00001;
        end else if (model_lu()) begin
            {e_pcw, e_ifw, e_fl, e_bub, e_frz} = 5'b00010;
        end else if (bus.branch_taken_i) begin
            {e_pcw, e_ifw, e_fl, e_bub, e_frz} = 5'b11100;
        end else begin
            {e_pcw, e_ifw, e_fl, e_bub, e_frz} = 5'b11000;
        end
        chk("PCWrite", 32'(bus.PCWrite_o), 32'(e_pcw));
        chk("IFID_write", 32'(bus.IFID_write_o), 32'(e_ifw));
        chk("IFID_flush", 32'(bus.IFID_flush_o), 32'(e_fl));
        chk("bubble_sel", 32'(bus.bubble_sel_o), 32'(e_bub));
        chk("freeze", 32'(bus.freeze_o), 32'(e_frz));
        chk("lu_cnt", 32'(bus.lu_cnt_o), 32'(m_lu_cnt));
        chk("miss_cyc_cnt", 32'(bus.miss_cyc_cnt_o), 32'(m_miss_cnt));
        chk("miss_timeout", 32'(bus.miss_timeout_o), 32'(m_flag));
    endtask

    task automatic model_edge();
        if (rst_i) begin
            m_in_miss  = 1'b0;
            m_lu_cnt   = 0;
            m_miss_cnt = 0;
            m_run_len  = 0;
            m_flag     = 1'b0;
        end else begin
            if (!bus.mem_stall_i && model_lu() && m_lu_cnt < CNT_MAX) m_lu_cnt++;
            if (m_in_miss && m_miss_cnt < CNT_MAX) m_miss_cnt++;
            if (m_run_len == MISS_TIMEOUT) m_flag = 1'b1;
            m_run_len = m_in_miss ? ((m_run_len < MISS_TIMEOUT) ? m_run_len + 1 : m_run_len) : 0;
            m_in_miss = bus.mem_stall_i;
        end
    endtask

    // mid-cycle compare (falls on the negative edge)
    task automatic settle();
        #4;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic set_in(input bit mr, input int rd, input int rs1, input int rs2,
                          input bit u2, input bit br, input bit st);
        bus.EX_MemRead_i   = mr;
        bus.EX_rd_i        = 5'(rd);
        bus.ID_rs1_i       = 5'(rs1);
        bus.ID_rs2_i       = 5'(rs2);
        bus.ID_uses_rs2_i  = u2;
        bus.branch_taken_i = br;
        bus.mem_stall_i    = st;
    endtask

    int stall_run;

    initial begin
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk_i);
        model_edge();
        #1;

        // reset held with cache stall asserted: safe outputs
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_PCWrite", 32'(bus.PCWrite_o), 32'd0);
            chk("rst_bubble", 32'(bus.bubble_sel_o), 32'd1);
            chk("rst_freeze", 32'(bus.freeze_o), 32'd0);
            advance();
        end
        rst_i = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("post_rst_lu_cnt", 32'(bus.lu_cnt_o), 32'd0);
        chk("post_rst_miss_cnt", 32'(bus.miss_cyc_cnt_o), 32'd0);
        chk("post_rst_PCWrite", 32'(bus.PCWrite_o), 32'd1);
        advance();

        // load-use via rs2
        set_in(1, 5, 0, 5, 1, 0, 0);
        settle();
        chk("lu_rs2_bubble", 32'(bus.bubble_sel_o), 32'd1);
        chk("lu_rs2_PCWrite", 32'(bus.PCWrite_o), 32'd0);
        chk("lu_rs2_IFIDw", 32'(bus.IFID_write_o), 32'd0);
        advance();
        // rd = x0 never hazards
        set_in(1, 0, 0, 0, 1, 0, 0);
        settle();
        chk("lu_cnt_one", 32'(bus.lu_cnt_o), 32'd1);
        chk("x0_bubble", 32'(bus.bubble_sel_o), 32'd0);
        chk("x0_PCWrite", 32'(bus.PCWrite_o), 32'd1);
        advance();
        // rs2 match ignored when rs2 unused
        set_in(1, 5, 3, 5, 0, 0, 0);
        settle();
        chk("no_rs2_bubble", 32'(bus.bubble_sel_o), 32'd0);
        advance();

        // load-use beats branch; branch flushes once hazard clears
        set_in(1, 5, 5, 0, 0, 1, 0);
        settle();
        chk("lu_br_flush", 32'(bus.IFID_flush_o), 32'd0);
        chk("lu_br_bubble", 32'(bus.bubble_sel_o), 32'd1);
        advance();
        set_in(0, 5, 5, 0, 0, 1, 0);
        settle();
        chk("br_flush", 32'(bus.IFID_flush_o), 32'd1);
        chk("br_PCWrite", 32'(bus.PCWrite_o), 32'd1);
        advance();

        // 10-cycle cache miss with load-use pending
        set_in(1, 5, 5, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("miss_freeze", 32'(bus.freeze_o), 32'd1);
            chk("miss_bubble", 32'(bus.bubble_sel_o), 32'd0);
            chk("miss_lu_hold", 32'(bus.lu_cnt_o), 32'd2);
            advance();
        end
        bus.mem_stall_i = 1'b0;
        settle();
        chk("after_miss_bubble", 32'(bus.bubble_sel_o), 32'd1);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("miss_cnt_ten", 32'(bus.miss_cyc_cnt_o), 32'd10);
        chk("miss_flag_set", 32'(bus.miss_timeout_o), 32'd1);
        advance();

        // reset in the middle of a miss
        bus.mem_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        rst_i = 1'b1;
        settle();
        advance();
        rst_i = 1'b0;
        bus.mem_stall_i = 1'b0;
        settle();
        chk("midmiss_rst_flag", 32'(bus.miss_timeout_o), 32'd0);
        advance();
        settle();
        chk("midmiss_rst_run", 32'(bus.miss_cyc_cnt_o), 32'd0);
        advance();

        // watchdog: 9 stall cycles trips an 8-cycle limit
        bus.mem_stall_i = 1'b1;
        for (int i = 0; i < 9; i++) begin settle(); advance(); end
        bus.mem_stall_i = 1'b0;
        settle();
        advance();
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("wdog_sticky", 32'(bus.miss_timeout_o), 32'd1);
            advance();
        end

        // counter saturation: 20 load-use cycles into a 4-bit counter
        rst_i = 1'b1;
        settle();
        advance();
        rst_i = 1'b0;
        set_in(1, 7, 7, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin settle(); advance(); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("lu_cnt_sat", 32'(bus.lu_cnt_o), 32'd15);
        advance();

        // random traffic
        stall_run = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 249) == 0);
            if (stall_run == 0 && $urandom_range(0, 11) == 0) stall_run = $urandom_range(1, 14);
            set_in($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   stall_run != 0);
            if (stall_run != 0) stall_run--;
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
